// File: rtl/ball_motion_engine.sv
// ---------------------------------------------------------------------------
// ball_motion_engine
//
// Purpose:
//   Moves the Pong ball one step for each rising edge of game_clock_i. It
//   bounces the ball off the top and bottom walls and off both paddles. It
//   also detects when a player misses. The rally score it produces feeds back
//   into the game-tick generator, so the ball speeds up as the rally goes on.
//
// Ports:
//   clk           system clock, the only clock
//   rst_n         asynchronous active-low reset
//   game_clock_i  slow square wave from the tick generator, synchronous to clk
//   serve_i       level input; launches the ball while idle
//   paddle_l_y_i  top y of the left paddle
//   paddle_r_y_i  top y of the right paddle
//   ball_x_o      left x of the ball
//   ball_y_o      top y of the ball
//   score_o       rally score, saturating
//   miss_l_o      one-clock pulse when the left player misses
//   miss_r_o      one-clock pulse when the right player misses
//   playing_o     high while a rally is in progress
// ---------------------------------------------------------------------------
module ball_motion_engine #(
   parameter int H_RES     = 640,
   parameter int V_RES     = 480,
   parameter int BALL_SIZE = 8,
   parameter int STEP      = 2,
   parameter int PADDLE_H  = 64,
   parameter int PADDLE_W  = 8,
   parameter int PADDLE_LX = 16,
   parameter int PADDLE_RX = 616,
   parameter int SCORE_MAX = 9
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       game_clock_i,
   input  logic       serve_i,
   input  logic [9:0] paddle_l_y_i,
   input  logic [9:0] paddle_r_y_i,
   output logic [9:0] ball_x_o,
   output logic [9:0] ball_y_o,
   output logic [3:0] score_o,
   output logic       miss_l_o,
   output logic       miss_r_o,
   output logic       playing_o
);

   // All geometry is compared at 11 bits so that sums such as y+size+step
   // can never wrap.
   localparam logic [10:0] HRES_W   = 11'(H_RES);
   localparam logic [10:0] VRES_W   = 11'(V_RES);
   localparam logic [10:0] BALL_W   = 11'(BALL_SIZE);
   localparam logic [10:0] STEP_W   = 11'(STEP);
   localparam logic [10:0] PH_W     = 11'(PADDLE_H);
   localparam logic [10:0] FACE_L   = 11'(PADDLE_LX + PADDLE_W);
   localparam logic [10:0] FACE_R   = 11'(PADDLE_RX);
   localparam logic [10:0] HIT_R_X  = 11'(PADDLE_RX - BALL_SIZE);
   localparam logic [10:0] BOTTOM_Y = 11'(V_RES - BALL_SIZE);
   localparam logic [9:0]  X_CENTRE = 10'((H_RES - BALL_SIZE) / 2);
   localparam logic [9:0]  Y_CENTRE = 10'((V_RES - BALL_SIZE) / 2);
   localparam logic [3:0]  SCORE_TOP = 4'(SCORE_MAX);

   typedef enum logic {
      IDLE = 1'b0,
      PLAY = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic [9:0]  x_q, x_d;
   logic [9:0]  y_q, y_d;
   logic        dx_pos_q, dx_pos_d;
   logic        dy_pos_q, dy_pos_d;
   logic [3:0]  score_q, score_d;
   logic        miss_l_q, miss_l_d;
   logic        miss_r_q, miss_r_d;
   logic        gc_q;

   logic        tick;
   logic [10:0] x_w, y_w, pl_w, pr_w, edge_w;
   logic [10:0] x_next_w, y_next_w;
   logic        dx_next, dy_next;
   logic        overlap_l, overlap_r, face_l, face_r;
   logic        hit, miss_l_hit, miss_r_hit;
   logic [3:0]  score_inc;

   // game_clock_i is already synchronous to clk. One register is enough to
   // find its rising edge, and that edge is the tick.
   assign tick   = game_clock_i & ~gc_q;

   assign x_w    = {1'b0, x_q};
   assign y_w    = {1'b0, y_q};
   assign pl_w   = {1'b0, paddle_l_y_i};
   assign pr_w   = {1'b0, paddle_r_y_i};
   assign edge_w = x_w + BALL_W;

   // The vertical extent of the ball is tested against each paddle. The
   // paddle inputs only matter on the tick clock, because that is the only
   // time these results are used.
   assign overlap_l = (y_w + BALL_W > pl_w) && (y_w < pl_w + PH_W);
   assign overlap_r = (y_w + BALL_W > pr_w) && (y_w < pr_w + PH_W);

   // A face is crossed when this step would take the leading edge from the
   // near side of the face to the far side. x >= F and x - STEP < F is
   // written here as x < F + STEP, which avoids an underflow.
   assign face_l = (x_w >= FACE_L) && (x_w < FACE_L + STEP_W);
   assign face_r = (edge_w <= FACE_R) && (edge_w + STEP_W > FACE_R);

   assign score_inc = (score_q >= SCORE_TOP) ? SCORE_TOP : score_q + 4'd1;

   // Vertical rule: clamp the ball against the top and bottom walls and
   // reflect it there. Otherwise it moves one step.
   always_comb begin
      y_next_w = y_w;
      dy_next  = dy_pos_q;
      if (!dy_pos_q) begin
         if (y_w < STEP_W) begin
            y_next_w = '0;
            dy_next  = 1'b1;
         end else begin
            y_next_w = y_w - STEP_W;
         end
      end else begin
         if (y_w + BALL_W + STEP_W > VRES_W) begin
            y_next_w = BOTTOM_Y;
            dy_next  = 1'b0;
         end else begin
            y_next_w = y_w + STEP_W;
         end
      end
   end

   // Horizontal rule: a paddle hit snaps the ball to the paddle face and
   // turns it around. A ball that crosses a face without overlapping the
   // paddle keeps going until it leaves the field, and that is a miss.
   always_comb begin
      x_next_w   = x_w;
      dx_next    = dx_pos_q;
      hit        = 1'b0;
      miss_l_hit = 1'b0;
      miss_r_hit = 1'b0;
      if (!dx_pos_q) begin
         if (face_l && overlap_l) begin
            x_next_w = FACE_L;
            dx_next  = 1'b1;
            hit      = 1'b1;
         end else if (x_w < STEP_W) begin
            miss_l_hit = 1'b1;
         end else begin
            x_next_w = x_w - STEP_W;
         end
      end else begin
         if (face_r && overlap_r) begin
            x_next_w = HIT_R_X;
            dx_next  = 1'b0;
            hit      = 1'b1;
         end else if (edge_w + STEP_W > HRES_W) begin
            miss_r_hit = 1'b1;
         end else begin
            x_next_w = x_w + STEP_W;
         end
      end
   end

   // Next-state logic. While idle the ball stays at the centre and ticks do
   // nothing. During play, each tick applies both axis rules to the values
   // from before the tick. A miss overrides everything: the ball goes back to
   // the centre and dx points at the player who missed, so that player
   // receives the next serve.
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      dx_pos_d = dx_pos_q;
      dy_pos_d = dy_pos_q;
      score_d  = score_q;
      miss_l_d = 1'b0;
      miss_r_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (serve_i) begin
               state_d = PLAY;
            end
         end
         PLAY: begin
            if (tick) begin
               if (miss_l_hit || miss_r_hit) begin
                  miss_l_d = miss_l_hit;
                  miss_r_d = miss_r_hit;
                  score_d  = '0;
                  x_d      = X_CENTRE;
                  y_d      = Y_CENTRE;
                  dx_pos_d = miss_r_hit;
                  state_d  = IDLE;
               end else begin
                  x_d      = x_next_w[9:0];
                  y_d      = y_next_w[9:0];
                  dx_pos_d = dx_next;
                  dy_pos_d = dy_next;
                  if (hit) begin
                     score_d = score_inc;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset aborts any rally at once and puts
   // the ball back at the centre, heading right and down.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         x_q      <= X_CENTRE;
         y_q      <= Y_CENTRE;
         dx_pos_q <= 1'b1;
         dy_pos_q <= 1'b1;
         score_q  <= '0;
         miss_l_q <= 1'b0;
         miss_r_q <= 1'b0;
         gc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         dx_pos_q <= dx_pos_d;
         dy_pos_q <= dy_pos_d;
         score_q  <= score_d;
         miss_l_q <= miss_l_d;
         miss_r_q <= miss_r_d;
         gc_q     <= game_clock_i;
      end
   end

   assign ball_x_o  = x_q;
   assign ball_y_o  = y_q;
   assign score_o   = score_q;
   assign miss_l_o  = miss_l_q;
   assign miss_r_o  = miss_r_q;
   assign playing_o = (state_q == PLAY);

endmodule

// File: tb/tb_ball_motion_engine.sv
// ---------------------------------------------------------------------------
// tb_ball_motion_engine
//
// Drives random serves and random paddle positions into ball_motion_engine,
// one game tick at a time. A behavioural model of the game is kept in
// integer arithmetic, and the DUT outputs are compared against it after
// every tick.
// ---------------------------------------------------------------------------
module tb_ball_motion_engine;

   logic       clk = 1'b0;
   logic       rstN;
   logic       gameClock;
   logic       serve;
   logic [9:0] paddleLY;
   logic [9:0] paddleRY;
   logic [9:0] ballX;
   logic [9:0] ballY;
   logic [3:0] score;
   logic       missL;
   logic       missR;
   logic       playing;

   int errors = 0;
   int checks = 0;

   // Model of the game state, kept as signed integers.
   int mX, mY, mDx, mDy, mScore;
   bit mPlay, mMissL, mMissR;

   ball_motion_engine dut (
      .clk          (clk),
      .rst_n        (rstN),
      .game_clock_i (gameClock),
      .serve_i      (serve),
      .paddle_l_y_i (paddleLY),
      .paddle_r_y_i (paddleRY),
      .ball_x_o     (ballX),
      .ball_y_o     (ballY),
      .score_o      (score),
      .miss_l_o     (missL),
      .miss_r_o     (missR),
      .playing_o    (playing)
   );

   always #5 clk = ~clk;

   // Compares one observed value with its expected value and counts the
   // result.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
      end
   endtask

   // Compares every DUT output against the model.
   task automatic checkAll(input string phase);
      checkOutput({phase, ":ball_x"},  int'(ballX),   mX);
      checkOutput({phase, ":ball_y"},  int'(ballY),   mY);
      checkOutput({phase, ":score"},   int'(score),   mScore);
      checkOutput({phase, ":playing"}, int'(playing), int'(mPlay));
      checkOutput({phase, ":miss_l"},  int'(missL),   int'(mMissL));
      checkOutput({phase, ":miss_r"},  int'(missR),   int'(mMissR));
   endtask

   task automatic modelReset();
      mX = 316; mY = 236; mDx = 1; mDy = 1; mScore = 0;
      mPlay = 0; mMissL = 0; mMissR = 0;
   endtask

   // One game tick of Pong, computed from the game rules.
   task automatic modelTick(input int pl, input int pr, input bit srv);
      int nx, ny, ndx, ndy;
      bit hitL, hitR;
      mMissL = 0;
      mMissR = 0;
      if (!mPlay) begin
         if (srv) mPlay = 1;
         return;
      end
      ny = mY; ndy = mDy;
      if (mDy < 0) begin
         if (mY < 2) begin ny = 0; ndy = 1; end
         else ny = mY - 2;
      end else begin
         if (mY + 8 + 2 > 480) begin ny = 472; ndy = -1; end
         else ny = mY + 2;
      end
      nx = mX; ndx = mDx;
      hitL = (mY + 8 > pl) && (mY < pl + 64);
      hitR = (mY + 8 > pr) && (mY < pr + 64);
      if (mDx < 0) begin
         if (mX >= 24 && mX - 2 < 24 && hitL) begin
            nx = 24; ndx = 1;
            mScore = (mScore >= 9) ? 9 : mScore + 1;
         end else if (mX < 2) mMissL = 1;
         else nx = mX - 2;
      end else begin
         if (mX + 8 <= 616 && mX + 8 + 2 > 616 && hitR) begin
            nx = 608; ndx = -1;
            mScore = (mScore >= 9) ? 9 : mScore + 1;
         end else if (mX + 8 + 2 > 640) mMissR = 1;
         else nx = mX + 2;
      end
      if (mMissL || mMissR) begin
         mX = 316; mY = 236; mScore = 0; mPlay = 0;
         mDx = mMissR ? 1 : -1;
      end else begin
         mX = nx; mY = ny; mDx = ndx; mDy = ndy;
      end
   endtask

   // Picks a paddle top. Most picks overlap the ball. The rest sit just
   // outside the overlap window or anywhere on the field.
   function automatic int pickPaddle(input int by, input bit alwaysHit);
      int r, lo;
      lo = (by > 63) ? by - 63 : 0;
      r = int'($urandom_range(99, 0));
      if (alwaysHit || r < 85) return int'($urandom_range(by + 7, lo));
      if (r < 93) return (by >= 64 && (r % 2) == 0) ? by - 64 : by + 8;
      return int'($urandom_range(1023, 0));
   endfunction

   // One full game_clock period: a rising edge, one checked clock, then a
   // check that any miss pulse has cleared again.
   task automatic applyStimulus(input int serveMode, input bit alwaysHit);
      int pl, pr;
      bit srv;
      pl = pickPaddle(mY, alwaysHit);
      pr = pickPaddle(mY, alwaysHit);
      srv = (serveMode < 0) ? ($urandom_range(3, 0) == 0) : serveMode[0];
      @(negedge clk);
      paddleLY  = 10'(pl);
      paddleRY  = 10'(pr);
      serve     = srv;
      gameClock = 1'b1;
      @(negedge clk);
      modelTick(pl, pr, srv);
      checkAll("tick");
      gameClock = 1'b0;
      serve     = 1'b0;
      @(negedge clk);
      checkOutput("miss_l_width", int'(missL), 0);
      checkOutput("miss_r_width", int'(missR), 0);
   endtask

   // Asserts reset between clock edges. The outputs must return to their
   // reset values before the next edge arrives.
   task automatic midReset();
      @(posedge clk);
      #2 rstN = 1'b0;
      #1;
      modelReset();
      checkAll("async_reset");
      @(negedge clk);
      @(negedge clk);
      rstN = 1'b1;
   endtask

   initial begin
      rstN      = 1'b0;
      gameClock = 1'b0;
      serve     = 1'b0;
      paddleLY  = '0;
      paddleRY  = '0;
      modelReset();
      repeat (3) @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);
      checkAll("reset");

      // A tick before the serve must not move the ball. The serve starts
      // play, and three ticks then move the ball down and to the right.
      applyStimulus(0, 1'b1);
      applyStimulus(1, 1'b1);
      checkOutput("serve_playing", int'(playing), 1);
      repeat (3) applyStimulus(0, 1'b1);
      checkOutput("serve_x", int'(ballX), 322);
      checkOutput("serve_y", int'(ballY), 242);

      // One long rally in which every return is hit, so the score reaches
      // its saturation value.
      for (int i = 0; i < 4000; i++) applyStimulus(-1, 1'b1);
      midReset();

      // Mixed play with misses, boundary overlaps and another async reset.
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(-1, 1'b0);
         if (i == 1500) midReset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
